// File: rtl/spi_slave_pkg.sv
// Shared state and command encodings for the parametrised SPI slave.
package spi_slave_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CHK_CMD,
      ST_WRITE,
      ST_READ_ADD,
      ST_READ_DATA,
      ST_READ_WAIT,
      ST_SHIFT_OUT,
      ST_DONE
   } state_e;

   localparam logic [1:0] CMD_WR_ADDR = 2'b00;
   localparam logic [1:0] CMD_WR_DATA = 2'b01;
   localparam logic [1:0] CMD_RD_ADDR = 2'b10;
   localparam logic [1:0] CMD_RD_DATA = 2'b11;

   // States in which a deselect counts as an aborted frame.
   function automatic logic frame_active(input state_e s);
      return (s != ST_IDLE) && (s != ST_DONE);
   endfunction

endpackage

// File: rtl/spi_shift_reg.sv
// Generic shift register: load has priority over shift, MSB is the serial tap.
module spi_shift_reg #(
   parameter int W = 9
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load_i,
   input  logic [W-1:0] load_data_i,
   input  logic         shift_i,
   input  logic         sin_i,
   output logic         sout_o,
   output logic [W-2:0] par_o
);

   logic [W-1:0] sr_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         sr_q <= '0;
      end else if (load_i) begin
         sr_q <= load_data_i;
      end else if (shift_i) begin
         sr_q <= {sr_q[W-2:0], sin_i};
      end
   end

   // Parallel view excludes the serial tap so {sout_o, par_o} is the full word.
   assign sout_o = sr_q[W-1];
   assign par_o  = sr_q[W-2:0];

endmodule

// File: rtl/spi_slave_param.sv
// SPI slave: 2-bit command + payload receive, read-address tracking, timed read-data return.
module spi_slave_param
   import spi_slave_pkg::*;
#(
   parameter int DATA_W  = 8,
   parameter int TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              SS_n,
   input  logic              MOSI,
   output logic              MISO,
   output logic [DATA_W+1:0] rx_data,
   output logic              rx_valid,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_valid,
   output logic              frame_err,
   output logic              busy
);

   localparam int CNT_W = $clog2(DATA_W + 2);
   localparam logic [CNT_W-1:0] RX_LAST = CNT_W'(DATA_W + 1);
   localparam logic [7:0]       TO_LAST = 8'(TIMEOUT - 1);
   localparam logic [DATA_W-1:0] TX_MARK = {1'b1, {(DATA_W-1){1'b0}}};

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
   logic [7:0]         to_cnt_q, to_cnt_d;
   logic               rd_seen_q, rd_seen_d;
   logic [DATA_W+1:0]  rx_data_q, rx_data_d;
   logic               rx_valid_q, rx_valid_d;
   logic               frame_err_q, frame_err_d;

   logic               rx_clr, rx_shift, rx_sout;
   logic [DATA_W-1:0]  rx_par;
   logic               tx_load, tx_shift, tx_sout;
   logic [DATA_W:0]    tx_load_val;
   logic [DATA_W-1:0]  tx_par;

   spi_shift_reg #(.W(DATA_W + 1)) u_rx_sr (
      .clk         (clk),
      .rst         (rst),
      .load_i      (rx_clr),
      .load_data_i ('0),
      .shift_i     (rx_shift),
      .sin_i       (MOSI),
      .sout_o      (rx_sout),
      .par_o       (rx_par)
   );

   // A marker 1 below the data walks up as bits leave; it reaching the top of
   // par_o means the last data bit is on MISO, so no separate tx counter is needed.
   spi_shift_reg #(.W(DATA_W + 1)) u_tx_sr (
      .clk         (clk),
      .rst         (rst),
      .load_i      (tx_load),
      .load_data_i (tx_load_val),
      .shift_i     (tx_shift),
      .sin_i       (1'b0),
      .sout_o      (tx_sout),
      .par_o       (tx_par)
   );

   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      to_cnt_d    = to_cnt_q;
      rd_seen_d   = rd_seen_q;
      rx_data_d   = rx_data_q;
      rx_valid_d  = 1'b0;
      frame_err_d = 1'b0;
      rx_clr      = 1'b0;
      rx_shift    = 1'b0;
      tx_load     = 1'b0;
      tx_load_val = '0;
      tx_shift    = 1'b0;

      if (state_q != ST_IDLE && SS_n) begin
         state_d     = ST_IDLE;
         frame_err_d = frame_active(state_q);
         bit_cnt_d   = '0;
         to_cnt_d    = '0;
         rx_clr      = 1'b1;
      end else begin
         case (state_q)
            ST_IDLE: begin
               rx_clr    = 1'b1;
               tx_load   = 1'b1;
               bit_cnt_d = '0;
               to_cnt_d  = '0;
               if (!SS_n) state_d = ST_CHK_CMD;
            end
            ST_CHK_CMD: begin
               rx_shift  = 1'b1;
               bit_cnt_d = CNT_W'(1);
               if (MOSI == CMD_WR_ADDR[1]) state_d = ST_WRITE;
               else if (rd_seen_q)         state_d = ST_READ_DATA;
               else                        state_d = ST_READ_ADD;
            end
            ST_WRITE, ST_READ_ADD, ST_READ_DATA: begin
               rx_shift = 1'b1;
               if (bit_cnt_q == RX_LAST) begin
                  bit_cnt_d  = '0;
                  rx_data_d  = {rx_sout, rx_par, MOSI};
                  rx_valid_d = 1'b1;
                  to_cnt_d   = '0;
                  if (state_q == ST_READ_ADD) begin
                     rd_seen_d = 1'b1;
                     state_d   = ST_DONE;
                  end else if (state_q == ST_READ_DATA) begin
                     rd_seen_d = 1'b0;
                     state_d   = ST_READ_WAIT;
                  end else begin
                     state_d = ST_DONE;
                  end
               end else begin
                  bit_cnt_d = bit_cnt_q + CNT_W'(1);
               end
            end
            ST_READ_WAIT: begin
               if (tx_valid) begin
                  tx_load     = 1'b1;
                  tx_load_val = {tx_data, 1'b1};
                  to_cnt_d    = '0;
                  state_d     = ST_SHIFT_OUT;
               end else if (to_cnt_q == TO_LAST) begin
                  frame_err_d = 1'b1;
                  to_cnt_d    = '0;
                  state_d     = ST_DONE;
               end else begin
                  to_cnt_d = to_cnt_q + 8'd1;
               end
            end
            ST_SHIFT_OUT: begin
               if (tx_par == TX_MARK) state_d  = ST_DONE;
               else                   tx_shift = 1'b1;
            end
            ST_DONE: ;
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         bit_cnt_q   <= '0;
         to_cnt_q    <= '0;
         rd_seen_q   <= 1'b0;
         rx_data_q   <= '0;
         rx_valid_q  <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         to_cnt_q    <= to_cnt_d;
         rd_seen_q   <= rd_seen_d;
         rx_data_q   <= rx_data_d;
         rx_valid_q  <= rx_valid_d;
         frame_err_q <= frame_err_d;
      end
   end

   assign MISO      = (state_q == ST_IDLE) ? 1'b0 : tx_sout;
   assign rx_data   = rx_data_q;
   assign rx_valid  = rx_valid_q;
   assign frame_err = frame_err_q;
   assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_spi_slave_param.sv
// Directed bench for spi_slave_param at DATA_W=8 and DATA_W=16.
module tb_spi_slave_param;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, ss_n, mosi, tx_valid, miso, rx_valid, frame_err, busy;
   logic [7:0] tx_data;
   logic [9:0] rx_data;

   logic        ss16, mosi16, txv16, miso16, rxv16, ferr16, busy16;
   logic [15:0] txd16;
   logic [17:0] rx16;

   int total = 0;
   int bad   = 0;

   spi_slave_param #(.DATA_W(8), .TIMEOUT(15)) u_dut8 (
      .clk(clk), .rst(rst), .SS_n(ss_n), .MOSI(mosi), .MISO(miso),
      .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data),
      .tx_valid(tx_valid), .frame_err(frame_err), .busy(busy)
   );

   spi_slave_param #(.DATA_W(16), .TIMEOUT(15)) u_dut16 (
      .clk(clk), .rst(rst), .SS_n(ss16), .MOSI(mosi16), .MISO(miso16),
      .rx_data(rx16), .rx_valid(rxv16), .tx_data(txd16),
      .tx_valid(txv16), .frame_err(ferr16), .busy(busy16)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Select, then shift nbits of the 10-bit frame MSB-first.
   task automatic send8(input logic [9:0] bits, input int nbits);
      ss_n = 1'b0;
      tick;
      check("busy_sel", busy, 1);
      for (int i = 0; i < nbits; i++) begin
         mosi = bits[9-i];
         tick;
         if (i < 9) check("rxv_early", rx_valid, 0);
      end
   endtask

   task automatic end_frame;
      ss_n = 1'b1;
      mosi = 1'b0;
      tick;
      check("idle_busy", busy, 0);
   endtask

   task automatic no_err_window(input string tag);
      int errs;
      errs = 0;
      for (int k = 0; k < 20; k++) begin
         tick;
         if (frame_err) errs++;
      end
      check(tag, errs, 0);
   endtask

   initial begin
      logic [7:0]  exp_tx;
      logic [17:0] w16;
      int k, ones;

      rst = 1'b1; ss_n = 1'b1; mosi = 1'b0; tx_valid = 1'b0; tx_data = '0;
      ss16 = 1'b1; mosi16 = 1'b0; txv16 = 1'b0; txd16 = '0;
      repeat (2) tick;
      check("rst_rx_data", rx_data, 0);
      check("rst_rx_valid", rx_valid, 0);
      check("rst_frame_err", frame_err, 0);
      check("rst_busy", busy, 0);
      check("rst_miso", miso, 0);
      check("rst_rx16", rx16, 0);
      rst = 1'b0;
      tick;

      // Write frame, with tx_valid held high to show it is ignored outside READ_WAIT
      tx_valid = 1'b1; tx_data = 8'hFF;
      send8(10'h0A5, 10);
      check("wr_rx_data", rx_data, 10'h0A5);
      check("wr_rx_valid", rx_valid, 1);
      mosi = 1'b1;
      tick;
      check("wr_rxv_one", rx_valid, 0);
      check("wr_miso_ign", miso, 0);
      tick;
      check("done_mosi_ign", rx_valid, 0);
      check("done_hold", rx_data, 10'h0A5);
      tx_valid = 1'b0;
      end_frame;
      check("wr_no_err", frame_err, 0);

      // Read-address then read-data with delayed tx_valid
      send8(10'h23C, 10);
      check("ra_rx_data", rx_data, 10'h23C);
      tick;
      end_frame;
      check("ra_no_err", frame_err, 0);

      send8(10'h300, 10);
      check("rd_rx_data", rx_data, 10'h300);
      check("rd_rx_valid", rx_valid, 1);
      tx_data = 8'hC3;
      tick;
      tx_valid = 1'b1;
      tick;
      tx_valid = 1'b0;
      exp_tx = 8'hC3;
      for (int i = 7; i >= 0; i--) begin
         check("miso_bit", miso, exp_tx[i]);
         tick;
      end
      check("miso_hold", miso, 1);
      check("shift_busy", busy, 1);
      tick;
      check("miso_hold2", miso, 1);
      check("shift_no_err", frame_err, 0);
      end_frame;
      check("miso_idle", miso, 0);

      // rd_addr_seen cleared by the read-data frame: this read is an address
      send8(10'h255, 10);
      check("ra2_rx_data", rx_data, 10'h255);
      no_err_window("ra2_no_timeout");
      end_frame;

      // Read-data without tx_valid: timeout after 15 wait cycles
      send8(10'h3AA, 10);
      check("rd2_rx_data", rx_data, 10'h3AA);
      k = 0; ones = 0;
      while (k < 40 && !frame_err) begin
         tick;
         k++;
         if (miso) ones++;
      end
      check("timeout_cycles", k, 15);
      check("timeout_miso", ones, 0);
      tick;
      check("timeout_pulse", frame_err, 0);
      end_frame;

      // Abort after 5 bits of a write
      send8(10'h0B7, 5);
      ss_n = 1'b1;
      tick;
      check("abort_err", frame_err, 1);
      check("abort_rxv", rx_valid, 0);
      check("abort_idle", busy, 0);
      check("abort_keep", rx_data, 10'h3AA);
      tick;
      check("abort_pulse", frame_err, 0);

      // Deselect coinciding with the last bit: abort wins
      send8(10'h0C3, 9);
      mosi = 1'b1;
      ss_n = 1'b1;
      tick;
      check("lastbit_rxv", rx_valid, 0);
      check("lastbit_err", frame_err, 1);
      check("lastbit_keep", rx_data, 10'h3AA);
      tick;

      // Deselect from DONE is not an error
      send8(10'h011, 10);
      check("wa_rx_data", rx_data, 10'h011);
      tick;
      end_frame;
      check("done_exit_err", frame_err, 0);

      // Reset mid-write with rd_addr_seen set
      send8(10'h211, 10);
      check("ra3_rx_data", rx_data, 10'h211);
      tick;
      end_frame;
      send8(10'h0AB, 5);
      rst = 1'b1; ss_n = 1'b1;
      tick;
      check("mrst_rx_data", rx_data, 0);
      check("mrst_rxv", rx_valid, 0);
      check("mrst_err", frame_err, 0);
      check("mrst_busy", busy, 0);
      check("mrst_miso", miso, 0);
      rst = 1'b0;
      tick;
      check("mrst_err2", frame_err, 0);
      send8(10'h377, 10);
      check("mrst_rd_rx", rx_data, 10'h377);
      no_err_window("mrst_rd_seen_clr");
      end_frame;

      // DATA_W=16 write-data frame
      w16 = 18'h1BEEF;
      ss16 = 1'b0;
      tick;
      for (int i = 0; i < 18; i++) begin
         mosi16 = w16[17-i];
         tick;
         if (i < 17) check("w16_rxv_early", rxv16, 0);
      end
      check("w16_rx_data", rx16, 18'h1BEEF);
      check("w16_rx_valid", rxv16, 1);
      tick;
      check("w16_rxv_one", rxv16, 0);
      ss16 = 1'b1;
      tick;
      check("w16_no_err", ferr16, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
